// File: rtl/regr_pipe_pkg.sv
// Shared constants for the elastic pipeline register and its slices.
// Slice occupancy encoding plus the capacity helper used to size the count.
package regr_pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_MAIN  = 2'b01;
  localparam logic [1:0] ST_BOTH  = 2'b11;

  function automatic int cap_of(input int depth, input int skid);
    return depth * (1 + ((skid != 0) ? 1 : 0));
  endfunction

endpackage

// File: rtl/regr_slice.sv
// One elastic register slice: a main entry, plus an optional skid entry that
// lets in_ready come straight from a register.
//
//   state    | meaning
//   ST_EMPTY | nothing held
//   ST_MAIN  | main entry valid, skid free
//   ST_BOTH  | main and skid valid (SKID=1 only); slice refuses input
module regr_slice
  import regr_pipe_pkg::*;
#(
  parameter int W    = 32,
  parameter int SKID = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [1:0]   state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         push, pop;

  if (SKID != 0) begin : g_skid
    assign in_ready = !flush && (state_q != ST_BOTH);
  end else begin : g_noskid
    // Ready ripples combinationally from downstream when the entry is held.
    assign in_ready = !flush && ((state_q == ST_EMPTY) || out_ready);
  end

  assign out_valid = !flush && (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            main_d  = in_data;
            state_d = ST_MAIN;
          end
        end
        ST_MAIN: begin
          if (push && pop) begin
            main_d = in_data;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end else if (push && (SKID != 0)) begin
            skid_d  = in_data;
            state_d = ST_BOTH;
          end
        end
        ST_BOTH: begin
          // Input is blocked here, so a pop simply promotes the skid entry.
          if (pop) begin
            main_d  = skid_q;
            state_d = ST_MAIN;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/regr_pipe.sv
// Elastic pipeline register: DEPTH valid/ready slices in a chain plus an
// occupancy counter of entries held across the whole pipe.
module regr_pipe
  import regr_pipe_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 2,
  parameter int SKID  = 1,
  localparam int CAP  = cap_of(DEPTH, SKID),
  localparam int CW   = $clog2(CAP + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [CW-1:0] count
);

  logic         v_s [DEPTH+1];
  logic         r_s [DEPTH+1];
  logic [W-1:0] d_s [DEPTH+1];

  logic [CW-1:0] count_q, count_d;
  logic          in_xfer, out_xfer;

  assign v_s[0]     = in_valid;
  assign d_s[0]     = in_data;
  assign in_ready   = r_s[0];
  assign out_valid  = v_s[DEPTH];
  assign out_data   = d_s[DEPTH];
  assign r_s[DEPTH] = out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slice
    regr_slice #(
      .W    (W),
      .SKID (SKID)
    ) u_slice (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (v_s[i]),
      .in_ready  (r_s[i]),
      .in_data   (d_s[i]),
      .out_valid (v_s[i+1]),
      .out_ready (r_s[i+1]),
      .out_data  (d_s[i+1])
    );
  end

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign count    = count_q;

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (in_xfer && !out_xfer) begin
      count_d = count_q + CW'(1);
    end else if (out_xfer && !in_xfer) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
